agu_order_scheduler: RTL and testbench
======================================

# agu_order_scheduler

Sequencer for the k2 order-translate pipeline. For each NTT stage it walks every butterfly pair and issues one (Order_0, Order_1) pair per cycle with the stage index `l`, honouring downstream backpressure. It tags the final pair with the AGU-done flag, then waits for that flag to return from the translate pipeline before signalling completion. It sits between the NTT top-level control and the order-translate stage that feeds the bank/memory-address interface.

## Interface
Parameters:
- `LOG_N`, 16: log2 of polynomial degree N; Order width.
- `RADIX_LOG`, 4: bits per radix digit; stage `l` pairs differ in bit `l*RADIX_LOG`.
- `STAGE_GAP`, 2: idle cycles inserted between stages (0 allowed).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- `num_stages`  in  3  stage count for this run; sampled with `start`.
- `issue_ready`  in  1  downstream can accept a pair this cycle.
- `agu_done_ret`  in  1  AGU-done flag returned from the translate pipeline output.
- `Order_0`  out  LOG_N  first butterfly index.
- `Order_1`  out  LOG_N  second butterfly index.
- `r_enable_k2`  out  1  pair valid this cycle.
- `AGU_done_k2`  out  1  marks the last pair of the last stage.
- `l`  out  3  current stage index.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, ISSUE, GAP and DRAIN. Every output is registered.
- IDLE:
  - `start`=1 with `num_stages`≠0 → ISSUE; clear `l`=0 and pair counter `i`=0.
  - `start`=1 with `num_stages`=0 → `done` pulses next cycle; stay IDLE; no issue.
- ISSUE:
  - Each cycle with `issue_ready`=1, register a pair: p=`l`*RADIX_LOG; `Order_0` = `i` with a 0 inserted at bit p (upper bits shifted up); `Order_1` = `Order_0` | (1<<p). Set `r_enable_k2`=1 and increment `i`.
  - `issue_ready`=0: `r_enable_k2`=0; `Order_0`/`Order_1`/`l` hold; `i` holds.
  - `i` is LOG_N-1 bits and spans 0..N/2-1.
  - Issuing `i`=N/2-1 when `l`=`num_stages`-1: `AGU_done_k2`=1 with that pair → DRAIN.
  - Issuing `i`=N/2-1 otherwise: `i`←0, `l`←`l`+1 → GAP, or stay in ISSUE if STAGE_GAP=0.
- GAP: count STAGE_GAP cycles with `r_enable_k2`=0 → ISSUE.
- DRAIN: `r_enable_k2`=0. `agu_done_ret`=1 → `done`=1 for one cycle, `busy`=0 → IDLE.
- Any `start` outside IDLE is ignored. `agu_done_ret` outside DRAIN is ignored.
- A p ≥ LOG_N (`num_stages` too large for LOG_N) is a configuration error. Behaviour is undefined; the bench must not drive it.

## Timing
- Reset values: all outputs 0, state IDLE, `i`=0, `l`=0. Assertion mid-run aborts immediately with no `done`.
- First `r_enable_k2` appears 2 cycles after `start` is sampled (IDLE→ISSUE, then registered pair), if `issue_ready`=1.
- Throughput is 1 pair/cycle. Per-stage issue cycles = N/2 + stalls; STAGE_GAP dead cycles separate stages.
- `AGU_done_k2` is high for exactly one cycle, coincident with `r_enable_k2`=1.
- `done` follows `agu_done_ret` by 1 cycle. `busy` drops in the same cycle `done` rises.
- `issue_ready` falling in the same cycle as the last pair of a stage: that pair is not issued; no stage advance until it is.

## Structure
- Package `agu_sched_pkg`: state enum `agu_state_e` {IDLE, ISSUE, GAP, DRAIN}, default widths (`LOG_N`, `RADIX_LOG`), stage-field width 3.
- Sub-module `order_bit_insert`: combinational zero-bit insertion of `i` at position p. Instantiated once; `Order_1` is derived by OR.

## Test plan
- LOG_N=8, RADIX_LOG=4, `num_stages`=2, `issue_ready`=1: 128 pairs at `l`=0 (first is 0/1, second 2/3), a 2-cycle gap, then 128 pairs at `l`=1 (first 0/16, last 239/255). `AGU_done_k2` fires on 239/255 only.
- Same config, return `agu_done_ret` 4 cycles after `AGU_done_k2`: `done` is a one-cycle pulse 1 cycle later, `busy` falls with it, and 256 pairs are issued in total.
- Toggle `issue_ready` randomly: no pair is dropped or duplicated, outputs hold while stalled, and the pair count is unchanged.
- `num_stages`=0 with `start`: `done` pulses next cycle, `busy` stays 0, no `r_enable_k2`.
- Drop `rst_n` in the middle of stage 1: all outputs are 0 immediately; a fresh `start` restarts at `l`=0, pair 0/1.
- STAGE_GAP=0: stage 1's first pair directly follows stage 0's last pair with no bubble; `start` pulsed during ISSUE is ignored.

Source files
------------

// File: rtl/agu_sched_pkg.sv
// rtl/agu_sched_pkg.sv - shared state type and widths for the k2 order scheduler
package agu_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} agu_state_e;

  localparam int DEF_LOG_N     = 16;
  localparam int DEF_RADIX_LOG = 4;
  localparam int STAGE_W       = 3;
  localparam int POS_W         = 8;

endpackage

// File: rtl/order_bit_insert.sv
// rtl/order_bit_insert.sv - inserts a zero bit into a pair index at position i_pos
module order_bit_insert
  import agu_sched_pkg::*;
#(
  parameter int LOG_N = DEF_LOG_N
) (
  input  logic [LOG_N-2:0] i_idx,
  input  logic [POS_W-1:0] i_pos,
  output logic [LOG_N-1:0] o_order
);

  logic [LOG_N-1:0] w_idx;
  logic [LOG_N-1:0] w_low_mask;

  assign w_idx      = {1'b0, i_idx};
  assign w_low_mask = (LOG_N'(1) << i_pos) - LOG_N'(1);
  // bits below i_pos stay put, bits at or above it move up one place
  assign o_order    = ((w_idx & ~w_low_mask) << 1) | (w_idx & w_low_mask);

endmodule

// File: rtl/agu_order_scheduler.sv
// rtl/agu_order_scheduler.sv - walks butterfly pairs per NTT stage and issues Order_0/Order_1
module agu_order_scheduler
  import agu_sched_pkg::*;
#(
  parameter int LOG_N     = DEF_LOG_N,
  parameter int RADIX_LOG = DEF_RADIX_LOG,
  parameter int STAGE_GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STAGE_W-1:0] num_stages,
  input  logic               issue_ready,
  input  logic               agu_done_ret,
  output logic [LOG_N-1:0]   Order_0,
  output logic [LOG_N-1:0]   Order_1,
  output logic               r_enable_k2,
  output logic               AGU_done_k2,
  output logic [STAGE_W-1:0] l,
  output logic               busy,
  output logic               done
);

  agu_state_e         r_state;
  logic [LOG_N-2:0]   r_i;
  logic [STAGE_W-1:0] r_stage;
  logic [STAGE_W-1:0] r_nstages;
  logic [POS_W-1:0]   r_gap;
  logic [LOG_N-1:0]   r_order_0;
  logic [LOG_N-1:0]   r_order_1;
  logic [STAGE_W-1:0] r_l;
  logic               r_en;
  logic               r_agu_done;
  logic               r_busy;
  logic               r_done;

  logic [POS_W-1:0]   w_pos;
  logic [LOG_N-1:0]   w_order_0;
  logic [LOG_N-1:0]   w_order_1;
  logic               w_last_pair;
  logic               w_last_stage;

  assign w_pos        = POS_W'(32'(r_stage) * RADIX_LOG);
  assign w_order_1    = w_order_0 | (LOG_N'(1) << w_pos);
  assign w_last_pair  = &r_i;
  assign w_last_stage = (r_stage == r_nstages - STAGE_W'(1));

  order_bit_insert #(.LOG_N(LOG_N)) u_insert (
    .i_idx   (r_i),
    .i_pos   (w_pos),
    .o_order (w_order_0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_stage    <= '0;
      r_nstages  <= '0;
      r_gap      <= '0;
      r_order_0  <= '0;
      r_order_1  <= '0;
      r_l        <= '0;
      r_en       <= 1'b0;
      r_agu_done <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_en       <= 1'b0;
      r_agu_done <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (num_stages != '0) begin
              r_state   <= ISSUE;
              r_i       <= '0;
              r_stage   <= '0;
              r_l       <= '0;
              r_nstages <= num_stages;
              r_busy    <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            r_order_0 <= w_order_0;
            r_order_1 <= w_order_1;
            r_l       <= r_stage;
            r_en      <= 1'b1;
            if (!w_last_pair) begin
              r_i <= r_i + 1'b1;
            end else if (w_last_stage) begin
              r_agu_done <= 1'b1;
              r_state    <= DRAIN;
            end else begin
              r_i     <= '0;
              r_stage <= r_stage + 1'b1;
              r_gap   <= '0;
              if (STAGE_GAP != 0) r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap == POS_W'(STAGE_GAP - 1)) r_state <= ISSUE;
          else r_gap <= r_gap + 1'b1;
        end
        DRAIN: begin
          // completion waits for the tagged pair to emerge from the translate pipeline
          if (agu_done_ret) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Order_0     = r_order_0;
  assign Order_1     = r_order_1;
  assign r_enable_k2 = r_en;
  assign AGU_done_k2 = r_agu_done;
  assign l           = r_l;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_agu_order_scheduler.sv
// tb/tb_agu_order_scheduler.sv - directed self-checking bench for agu_order_scheduler
module tb_agu_order_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] num_stages = 3'd0;
  logic       issue_ready = 1'b0;
  logic       agu_done_ret = 1'b0;
  logic [7:0] Order_0, Order_1;
  logic       r_enable_k2, AGU_done_k2, busy, done;
  logic [2:0] l;

  logic       z_start = 1'b0;
  logic [2:0] z_num = 3'd0;
  logic       z_ready = 1'b0;
  logic       z_ret = 1'b0;
  logic [7:0] z_o0, z_o1;
  logic       z_en, z_agu, z_busy, z_done;
  logic [2:0] z_l;

  int total = 0;
  int bad = 0;
  int exp_o0 [256];
  int exp_o1 [256];
  int exp_l [256];

  always #5 clk = ~clk;

  agu_order_scheduler #(.LOG_N(8), .RADIX_LOG(4), .STAGE_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_stages(num_stages),
    .issue_ready(issue_ready), .agu_done_ret(agu_done_ret),
    .Order_0(Order_0), .Order_1(Order_1), .r_enable_k2(r_enable_k2),
    .AGU_done_k2(AGU_done_k2), .l(l), .busy(busy), .done(done)
  );

  agu_order_scheduler #(.LOG_N(8), .RADIX_LOG(4), .STAGE_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(z_start), .num_stages(z_num),
    .issue_ready(z_ready), .agu_done_ret(z_ret),
    .Order_0(z_o0), .Order_1(z_o1), .r_enable_k2(z_en),
    .AGU_done_k2(z_agu), .l(z_l), .busy(z_busy), .done(z_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_xform(input bit always_ready, input int ret_delay);
    int idx, ndone, agu_idx, ret_cyc, last_c, first_c;
    bit fin;
    idx = 0; ndone = 0; agu_idx = -1; ret_cyc = -1; last_c = 0; first_c = 0; fin = 0;
    start = 1'b1; num_stages = 3'd2; issue_ready = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_pair_first_cycle", r_enable_k2, 0);
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      issue_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
      agu_done_ret = (cyc == ret_cyc);
      tick();
      if (agu_done_ret) begin
        check("done_pulse", done, 1);
        check("busy_falls", busy, 0);
        fin = 1;
      end else begin
        check("done_low", done, 0);
        check("busy_high", busy, 1);
      end
      if (r_enable_k2) begin
        if (idx < 256) begin
          check("order0", Order_0, exp_o0[idx]);
          check("order1", Order_1, exp_o1[idx]);
          check("stage_l", l, exp_l[idx]);
        end
        if (always_ready && idx == 0)   check("first_pair", {Order_0, Order_1}, 16'h0001);
        if (always_ready && idx == 1)   check("second_pair", {Order_0, Order_1}, 16'h0203);
        if (always_ready && idx == 128) check("stage1_first", {Order_0, Order_1}, 16'h0010);
        if (always_ready && idx == 255) check("stage1_last", {Order_0, Order_1}, 16'hEFFF);
        if (idx == 127) last_c = cyc;
        if (idx == 128) first_c = cyc;
        if (AGU_done_k2) begin
          ndone++;
          agu_idx = idx;
          ret_cyc = cyc + ret_delay;
        end
        idx++;
      end else begin
        if (AGU_done_k2) ndone++;
        if (idx > 0 && idx <= 256) begin
          check("hold_order0", Order_0, exp_o0[idx-1]);
          check("hold_order1", Order_1, exp_o1[idx-1]);
          check("hold_l", l, exp_l[idx-1]);
        end
      end
    end
    agu_done_ret = 1'b0;
    issue_ready = 1'b1;
    check("run_completed", fin, 1);
    check("pair_count", idx, 256);
    check("agu_done_count", ndone, 1);
    check("agu_done_on_last", agu_idx, 255);
    if (always_ready) check("stage_gap_cycles", first_c - last_c, 3);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("no_pair_idle", r_enable_k2, 0);
  endtask

  initial begin
    int idx, ret_cyc, last_c, first_c;
    bit fin;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 128; i++) begin
        int p;
        p = 4 * s;
        exp_o0[s*128+i] = ((i >> p) << (p + 1)) | (i & ((1 << p) - 1));
        exp_o1[s*128+i] = exp_o0[s*128+i] | (1 << p);
        exp_l[s*128+i]  = s;
      end
    end

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_order0", Order_0, 0);
    check("rst_order1", Order_1, 0);
    check("rst_en", r_enable_k2, 0);
    check("rst_agu", AGU_done_k2, 0);
    check("rst_l", l, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    run_xform(1'b1, 4);
    run_xform(1'b0, 2);

    start = 1'b1; num_stages = 3'd0;
    tick();
    start = 1'b0;
    check("zero_stage_done", done, 1);
    check("zero_stage_busy", busy, 0);
    check("zero_stage_en", r_enable_k2, 0);
    tick();
    check("zero_stage_done_drop", done, 0);
    check("zero_stage_busy2", busy, 0);
    check("zero_stage_en2", r_enable_k2, 0);

    start = 1'b1; num_stages = 3'd2; issue_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 145; c++) tick();
    check("mid_run_stage", l, 1);
    check("mid_run_en", r_enable_k2, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_order0", Order_0, 0);
    check("abort_order1", Order_1, 0);
    check("abort_en", r_enable_k2, 0);
    check("abort_l", l, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    check("abort_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_en", r_enable_k2, 1);
    check("restart_pair", {Order_0, Order_1}, 16'h0001);
    check("restart_l", l, 0);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    z_start = 1'b1; z_num = 3'd2; z_ready = 1'b1;
    tick();
    z_start = 1'b0;
    idx = 0; ret_cyc = -1; last_c = 0; first_c = 0; fin = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      z_start = (c == 50);
      z_ret = (c == ret_cyc);
      tick();
      if (z_ret) begin
        check("gap0_done", z_done, 1);
        check("gap0_busy_falls", z_busy, 0);
        fin = 1;
      end
      if (z_en) begin
        if (idx < 256) begin
          check("gap0_order0", z_o0, exp_o0[idx]);
          check("gap0_order1", z_o1, exp_o1[idx]);
          check("gap0_l", z_l, exp_l[idx]);
        end
        if (idx == 127) last_c = c;
        if (idx == 128) first_c = c;
        if (z_agu) ret_cyc = c + 1;
        idx++;
      end
    end
    z_start = 1'b0;
    z_ret = 1'b0;
    check("gap0_completed", fin, 1);
    check("gap0_pair_count", idx, 256);
    check("gap0_no_bubble", first_c - last_c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
